out_mux_sched: RTL and testbench

- Round-robin scheduler that drives the 4-bit select of the 16:1 result mux (OutMuxAdd).
- Each of the 16 result slots raises a sticky request when its data is ready.
- The block picks one slot, holds the select stable, and presents a valid/ready transfer to the downstream consumer.
- On handshake it acknowledges the slot. It sits between the factorization result registers and the serial/output stage.

---
 rtl/out_mux_sched_pkg.sv | 6 +
 rtl/out_mux_sched_rr_pick16.sv | 21 ++
 rtl/out_mux_sched.sv | 65 ++++++
 tb/tb_out_mux_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/out_mux_sched_pkg.sv
// out_mux_pkg: shared widths and scheduler state encoding for out_mux_sched
package out_mux_pkg;
  localparam int SEL_W = 4;
  localparam int NSLOT = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_VALID} state_t;
endpackage

// File: rtl/out_mux_sched_rr_pick16.sv
// rr_pick16: rotate-priority encoder, first set req bit at or after ptr (mod 16)
module rr_pick16
  import out_mux_pkg::*;
(
  input  logic [NSLOT-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [2*NSLOT-1:0] dbl;
  logic [NSLOT-1:0]   rot;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NSLOT-1:0];
  assign any = |req;
  // descending scan so the lowest rotated position (closest to ptr) wins
  always_comb begin
    idx = ptr;
    for (int i = NSLOT - 1; i >= 0; i--)
      if (rot[i]) idx = ptr + SEL_W'(i);
  end
endmodule

// File: rtl/out_mux_sched.sv
// out_mux_sched: round-robin scheduler driving the 16:1 result mux select
module out_mux_sched
  import out_mux_pkg::*;
#(
  parameter int SETTLE = 0,
  parameter int NSLOT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] OutMuxAdd,
  output logic             out_valid,
  output logic [15:0]      ack,
  output logic             busy
);
  if (NSLOT != out_mux_pkg::NSLOT) begin : g_bad_nslot
    $error("out_mux_sched: NSLOT must be 16");
  end
  if (SETTLE < 0 || SETTLE > 7) begin : g_bad_settle
    $error("out_mux_sched: SETTLE must be 0..7");
  end
  localparam logic [2:0] SCNT = SETTLE > 0 ? 3'(SETTLE - 1) : 3'd0;
  localparam state_t     POST = SETTLE > 0 ? ST_SETTLE : ST_VALID;
  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [2:0]       settle_cnt;
  logic [SEL_W-1:0] pick;
  logic             any;
  rr_pick16 u_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick),
    .any (any)
  );
  assign out_valid = state == ST_VALID;
  assign busy      = state != ST_IDLE;
  assign ack       = out_valid && out_ready ? 16'h1 << OutMuxAdd : 16'h0;
  // with SETTLE=0 the SETTLE state is unreachable, so the counter never gates VALID
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      OutMuxAdd  <= '0;
      rr_ptr     <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any) begin
          OutMuxAdd  <= pick;
          settle_cnt <= SCNT;
          state      <= POST;
        end
        ST_SETTLE: if (settle_cnt == 3'd0) state <= ST_VALID;
                   else settle_cnt <= settle_cnt - 3'd1;
        ST_VALID: if (out_ready) begin
          rr_ptr <= OutMuxAdd + SEL_W'(1);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  a_req_held: assert property (@(posedge clk) disable iff (rst) out_valid |-> req[OutMuxAdd])
    else $error("out_mux_sched: req[%0d] dropped before ack", OutMuxAdd);
endmodule

// File: tb/tb_out_mux_sched.sv
// tb_out_mux_sched: scoreboard bench for out_mux_sched with SETTLE=0 and SETTLE=3 instances
module tb_out_mux_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0, req1 = '0;
  logic        out_ready = 1'b0, ready1 = 1'b0;
  logic [3:0]  sel, sel1;
  logic        out_valid, valid1, busy, busy1;
  logic [15:0] ack, ack1;
  int          vectors = 0, errs = 0;
  int          q0[$], q1[$];
  always #5 clk = ~clk;
  out_mux_sched #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .OutMuxAdd(sel), .out_valid(out_valid), .ack(ack), .busy(busy)
  );
  out_mux_sched #(.SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .out_ready(ready1),
    .OutMuxAdd(sel1), .out_valid(valid1), .ack(ack1), .busy(busy1)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic hs_check(input string n, input logic [3:0] s, input logic [15:0] a, ref int q[$]);
    logic [15:0] one;
    int e;
    one = 16'h1;
    vectors++;
    if (q.size() == 0) begin
      errs++;
      $display("FAIL %s unexpected grant got %0d want none", n, s);
    end else begin
      e = q.pop_front();
      if (s !== 4'(e) || a !== one << e) begin
        errs++;
        $display("FAIL %s grant got sel=%0d ack=%h want sel=%0d ack=%h", n, s, a, e, one << e);
      end
    end
  endtask
  always @(negedge clk) if (!rst && out_valid && out_ready) hs_check("hs0", sel, ack, q0);
  always @(negedge clk) if (!rst && valid1 && ready1) hs_check("hs1", sel1, ack1, q1);
  // advance one cycle; a slot acked at this edge drops its request like a real source
  task automatic tick(input bit autoclr = 1'b1);
    logic h;
    logic [3:0] s;
    h = out_valid & out_ready;
    s = sel;
    @(posedge clk);
    #1;
    if (h && autoclr) req[s] = 1'b0;
  endtask
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (req != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(req != 0), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) tick();
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    // SETTLE=3 latency on the second instance
    req1 = 16'h0004; ready1 = 1'b1; q1.push_back(2);
    tick();
    @(negedge clk);
    chk("s3_sel", sel1, 2);
    chk("s3_busy_c1", busy1, 1);
    chk("s3_valid_c1", valid1, 0);
    for (int c = 2; c <= 3; c++) begin
      tick();
      @(negedge clk);
      chk("s3_valid_early", valid1, 0);
      chk("s3_busy_mid", busy1, 1);
    end
    tick();
    @(negedge clk);
    chk("s3_valid_c4", valid1, 1);
    tick();
    req1 = '0;
    @(negedge clk);
    chk("s3_idle", busy1, 0);
    // single request, SETTLE=0
    req = 16'h0010; out_ready = 1'b1; q0.push_back(4);
    tick();
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_sel", sel, 4);
    chk("single_ack", ack, 16'h0010);
    tick();
    @(negedge clk);
    chk("single_idle", busy, 0);
    // rr_ptr now 5: scan 5..15,0..3 finds 3 before 4
    req = 16'h0018; q0.push_back(3); q0.push_back(4);
    drain(20);
    // round robin with wrap from a fresh pointer
    do_reset();
    req = 16'h8001; q0.push_back(0); q0.push_back(15);
    drain(20);
    req = 16'h0001; q0.push_back(0);
    drain(20);
    // all slots requesting: strict rotation twice
    do_reset();
    req = 16'hFFFF;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 16; i++) q0.push_back(i);
    repeat (64) tick(1'b0);
    req = '0;
    tick();
    chk("ffff_queue", q0.size(), 0);
    // backpressure on slot 7
    do_reset();
    req = 16'h0080; out_ready = 1'b0; q0.push_back(7);
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sel", sel, 7);
      chk("bp_ack", ack, 0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ack_release", ack, 16'h0080);
    tick();
    @(negedge clk);
    chk("bp_ack_once", ack, 0);
    chk("bp_valid_drop", out_valid, 0);
    // reset while VALID on slot 9, then regrant
    out_ready = 1'b0; req = 16'h0200;
    tick();
    @(negedge clk);
    chk("mid_valid", out_valid, 1);
    chk("mid_sel", sel, 9);
    do_reset();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    out_ready = 1'b1; q0.push_back(9);
    drain(20);
    // late arrival of bit 15 while 14 is held; pointer wraps to 0
    do_reset();
    req = 16'h2000; q0.push_back(13);
    drain(20);
    out_ready = 1'b0; req = 16'h4000; q0.push_back(14);
    tick();
    req[15] = 1'b1;
    tick();
    @(negedge clk);
    chk("late_sel_held", sel, 14);
    out_ready = 1'b1; q0.push_back(15);
    drain(20);
    req = 16'h8001; q0.push_back(0); q0.push_back(15);
    drain(20);
    repeat (2) tick();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
